// File: rtl/pwm_stream_if.sv
// Two-lane coefficient stream into and out of pwm_stream.
// acc_start/acc_done exist only when PWM_ACC_EN is defined.
interface pwm_stream_if #(
  parameter int DATA_WIDTH = 12
);
  logic                             in_en;
  logic [1:0][1:0][DATA_WIDTH-1:0]  in;
  logic                             out_en;
  logic [1:0][DATA_WIDTH-1:0]       out;
  logic                             out_last;
  logic                             busy;
`ifdef PWM_ACC_EN
  logic                             acc_start;
  logic                             acc_done;

  modport master (output in_en, in, acc_start, acc_done,
                  input  out_en, out, out_last, busy);
  modport slave  (input  in_en, in, acc_start, acc_done,
                  output out_en, out, out_last, busy);
`else
  modport master (output in_en, in,
                  input  out_en, out, out_last, busy);
  modport slave  (input  in_en, in,
                  output out_en, out, out_last, busy);
`endif
endinterface

// File: rtl/pwm_stream.sv
// Two-lane pointwise a*b mod Q (Barrett) for NTT-domain streams, fixed latency, frame-last tagging.
// Define PWM_ACC_EN to add the per-beat multiply-accumulate stage (latency grows by one cycle).
module pwm_stream #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int N          = 256
) (
  input  logic         clk,
  input  logic         rst,
  pwm_stream_if.slave  strm
);
  localparam int NB  = N / 2;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam longint unsigned M_L = (64'd1 << PW) / 64'(Q);
  localparam int MW  = $clog2(M_L + 1);
  localparam int PMW = PW + MW;
  localparam int RW  = $clog2(2 * Q);
  localparam logic [DATA_WIDTH-1:0] QV = DATA_WIDTH'(Q);
  localparam logic [MW-1:0]         MV = MW'(M_L);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       beat_last_d;
  logic [3:0]                 v_q, last_q;
  logic [1:0][DATA_WIDTH-1:0] a0_q, b0_q;
  logic [1:0][PW-1:0]         p1_q, p1_d, p2_q;
  logic [1:0][MW-1:0]         qe2_q, qe2_d;
  logic [1:0][RW-1:0]         r3_q, r3_d;
  logic [1:0][DATA_WIDTH-1:0] red_d;
  logic                       out_en_q, out_last_q;
  logic [1:0][DATA_WIDTH-1:0] out_q;

  // Quotient estimate is at most one low, so r3 < 2Q and one subtract finishes the reduction.
  always_comb begin
    beat_last_d = (cnt_q == CW'(NB - 1));
    cnt_d       = cnt_q;
    if (strm.in_en) cnt_d = beat_last_d ? '0 : cnt_q + CW'(1);
    for (int i = 0; i < 2; i++) begin
      p1_d[i]  = PW'(a0_q[i]) * PW'(b0_q[i]);
      qe2_d[i] = MW'((PMW'(p1_q[i]) * PMW'(MV)) >> PW);
      r3_d[i]  = RW'(p2_q[i] - PW'(qe2_q[i]) * PW'(QV));
      red_d[i] = (r3_q[i] >= RW'(QV)) ? DATA_WIDTH'(r3_q[i] - RW'(QV))
                                      : DATA_WIDTH'(r3_q[i]);
    end
  end

`ifdef PWM_ACC_EN
  logic                       start_hold_q, done_hold_q;
  logic                       first_d, start_tag_d, done_tag_d;
  logic [4:0]                 start_q, done_q;
  logic [4:0][CW-1:0]         idx_q;
  logic                       v4_q, last4_q;
  logic [1:0][DATA_WIDTH-1:0] prod4_q, rd_q, acc_d;
  logic [1:0][DATA_WIDTH:0]   sum_d;
  logic [1:0][DATA_WIDTH-1:0] acc_mem [NB];

  always_comb begin
    first_d     = (cnt_q == '0);
    start_tag_d = first_d ? strm.acc_start : start_hold_q;
    done_tag_d  = first_d ? strm.acc_done  : done_hold_q;
    for (int i = 0; i < 2; i++) begin
      sum_d[i] = {1'b0, rd_q[i]} + {1'b0, prod4_q[i]};
      if (start_q[4])
        acc_d[i] = prod4_q[i];
      else if (sum_d[i] >= {1'b0, QV})
        acc_d[i] = DATA_WIDTH'(sum_d[i] - {1'b0, QV});
      else
        acc_d[i] = DATA_WIDTH'(sum_d[i]);
    end
  end

  // Synchronous-read RAM; the entry written this edge is forwarded so back-to-back RMW stays exact.
  always_ff @(posedge clk) begin
    if (v4_q) acc_mem[idx_q[4]] <= acc_d;
    rd_q <= (v4_q && (idx_q[4] == idx_q[3])) ? acc_d : acc_mem[idx_q[3]];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      v_q        <= '0;
      last_q     <= '0;
      a0_q       <= '0;
      b0_q       <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      qe2_q      <= '0;
      r3_q       <= '0;
      out_en_q   <= 1'b0;
      out_last_q <= 1'b0;
      out_q      <= '0;
`ifdef PWM_ACC_EN
      start_hold_q <= 1'b0;
      done_hold_q  <= 1'b0;
      start_q      <= '0;
      done_q       <= '0;
      idx_q        <= '0;
      v4_q         <= 1'b0;
      last4_q      <= 1'b0;
      prod4_q      <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      v_q    <= {v_q[2:0], strm.in_en};
      last_q <= {last_q[2:0], strm.in_en & beat_last_d};
      a0_q   <= {strm.in[1][0], strm.in[0][0]};
      b0_q   <= {strm.in[1][1], strm.in[0][1]};
      p1_q   <= p1_d;
      p2_q   <= p1_q;
      qe2_q  <= qe2_d;
      r3_q   <= r3_d;
`ifdef PWM_ACC_EN
      if (strm.in_en && first_d) begin
        start_hold_q <= strm.acc_start;
        done_hold_q  <= strm.acc_done;
      end
      start_q    <= {start_q[3:0], start_tag_d};
      done_q     <= {done_q[3:0], done_tag_d};
      idx_q      <= {idx_q[3:0], cnt_q};
      v4_q       <= v_q[3];
      last4_q    <= last_q[3];
      prod4_q    <= red_d;
      out_en_q   <= v4_q & done_q[4];
      out_last_q <= v4_q & done_q[4] & last4_q;
      if (v4_q && done_q[4]) out_q <= acc_d;
`else
      out_en_q   <= v_q[3];
      out_last_q <= last_q[3];
      if (v_q[3]) out_q <= red_d;
`endif
    end
  end

  assign strm.out_en   = out_en_q;
  assign strm.out_last = out_last_q;
  assign strm.out      = out_q;
`ifdef PWM_ACC_EN
  assign strm.busy     = (cnt_q != '0) | (|v_q) | v4_q;
`else
  assign strm.busy     = (cnt_q != '0) | (|v_q);
`endif

endmodule

// File: doc/pwm_stream.md
Name: pwm_stream

Overview:
- Pointwise modular multiplier in the NTT domain.
- Sits directly downstream of the NTT: it consumes the 2-coefficient/cycle NTT output stream plus a second operand stream, multiplies them mod Q, and feeds the INTT input (2 coefficients/cycle).
- Fully pipelined, non-stalling, frame-aware: one frame = one polynomial of N coefficients = N/2 beats.

Parameters:
- DATA_WIDTH, 12: coefficient width in bits.
- Q, 3329: modulus. Inputs are guaranteed < Q.
- N, 256: coefficients per polynomial. Must be even and a power of two.
- LAT, 4: fixed input-to-output latency in cycles, macro off.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_en  in  1  input beat valid.
- in  in  [2][2] x DATA_WIDTH  in[i][0] is operand a, in[i][1] is operand b, for lane i.
- out_en  out  1  output beat valid.
- out  out  [2] x DATA_WIDTH  out[i] = (in[i][0]*in[i][1]) mod Q.
- out_last  out  1  high with out_en on the final beat of a frame.
- busy  out  1  a frame is partially received, or the pipeline holds a valid beat.

Behaviour:
- Reset (rst=0, async): out_en=0, out=0, out_last=0, busy=0, all pipeline valids cleared, beat counter=0. Effective on any cycle, including mid-frame; the partial frame is discarded and no output follows.
- Handshake: no backpressure. Every cycle with in_en=1 is one beat. in_en may drop for any number of cycles inside a frame; the beat counter holds during the gap.
- Latency: a beat sampled on edge k appears with out_en=1 on edge k+LAT. Lanes are independent.
- Gaps are preserved: output gaps match input gaps exactly.
- Arithmetic:
  - Full 2*DATA_WIDTH-bit product, then reduction to [0, Q-1]. Barrett with final conditional subtract; constants derived from Q.
  - Result must be exact for all a, b < Q. Internal widths must not overflow at a = b = Q-1.
- Beat counter: counts in_en beats 0..N/2-1 and wraps to 0 after N/2-1.
  - Counter value N/2-1 tags the beat as last. The tag travels with the data through the pipeline and drives out_last.
- busy = (beat counter != 0) OR (any pipeline valid bit set).
- out holds its last value when out_en=0. It is not required to be zero.
- Back-to-back frames need no idle cycle: the first beat of frame n+1 may follow the last beat of frame n on the next cycle.

Optional Feature:
- Macro: PWM_ACC_EN (multiply-accumulate for matrix-vector products).
- With macro:
  - Extra inputs acc_start (1) and acc_done (1), sampled on the first beat of each frame and held internally for that frame.
  - Internal accumulator RAM: N/2 x 2 x DATA_WIDTH, indexed by beat number.
  - acc_start=1: entry = product. acc_start=0: entry = (entry + product) mod Q, result in [0, Q-1].
  - out_en/out_last are asserted only for frames tagged acc_done=1, and out carries the accumulated sum.
  - Frames tagged acc_done=0 produce no output beats.
  - Latency becomes LAT+1.
  - Read-modify-write on the same entry in consecutive frames must be correct. Forward the value if the RAM read would be stale.
  - Reset does not clear the RAM. The next frame must use acc_start=1.
- Without macro: the extra ports, the RAM and the latency increase are absent. Every frame is output.

Test Plan:
1. One beat, lane0 (a=1, b=1), lane1 (a=3328, b=3328) -> 4 cycles later out_en=1, out[0]=1, out[1]=1.
2. Beat lane0 (2000, 2000), lane1 (1234, 0) -> out[0]=1871, out[1]=0. Also 1024 random beats checked against a mod-Q reference model.
3. Full frame of 128 contiguous beats, then a second frame immediately after -> out_last high exactly on output beats 128 and 256. busy drops 4 cycles after the last input beat.
4. Frame with random in_en gaps (about 50% duty) -> output valid pattern equals the input pattern shifted by 4 cycles. out_last appears on the 128th valid beat only.
5. Assert rst=0 after 60 beats of a frame, release, then send a full frame -> nothing from the aborted frame appears. out_last appears on the 128th beat of the new frame only.
6. PWM_ACC_EN:
   - Frame 1: acc_start=1, acc_done=0, all operands (1, 1) -> no output.
   - Frame 2: acc_start=0, acc_done=1, operands (3328, 1) -> 128 output beats of 0 (1+3328 mod Q), latency 5.
   - Repeat frame 2 with operands (2, 3) -> every output = 6+1 = 7 (frame 1 product 1 + frame 2 product 6).
